// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised SPI master (width, bit order, multi-CS, CS hold); SPI_3WIRE_EN adds rx-only 3-wire mode
module spi_master_gen #(
  parameter logic [27:0] SYS_CLK   = 28'd50_000_000,
  parameter logic [27:0] SPI_SCLK  = 28'd1_000_000,
  parameter int          DATA_W    = 8,
  parameter int          CS_NUM    = 1,
  parameter logic        SPI_CPOL  = 1'b0,
  parameter logic        SPI_CPHA  = 1'b0,
  parameter logic        LSB_FIRST = 1'b0,
  parameter logic        CS_POL    = 1'b1,
  localparam int         CS_W      = CS_NUM > 1 ? $clog2(CS_NUM) : 1
) (
  input  logic              spi_clk,
  input  logic              spi_rst_n,
  input  logic              spi_wr_en,
  input  logic [CS_W-1:0]   spi_cs_sel,
  input  logic              spi_cs_hold,
  input  logic [DATA_W-1:0] spi_data_in,
  output logic [DATA_W-1:0] spi_data_out,
  output logic              spi_wr_ack,
  output logic              spi_busy,
  output logic [CS_NUM-1:0] spi_cs,
  output logic              spi_sclk,
  output logic              spi_mosi,
`ifdef SPI_3WIRE_EN
  input  logic              spi_rx_only,
  output logic              spi_mosi_oe,
`endif
  input  logic              spi_miso
);
  localparam logic [27:0] HD_RAW = SYS_CLK / (SPI_SCLK << 1);
  localparam logic [27:0] HD_M1 = (HD_RAW == 28'd0) ? 28'd0 : HD_RAW - 28'd1;
  localparam int FIRST = LSB_FIRST ? 0 : DATA_W - 1;
  localparam logic [6:0] LAST_EDGE = 7'(2 * DATA_W);
  localparam logic [CS_NUM-1:0] CS_OFF = {CS_NUM{~CS_POL}};
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, TAIL = 3'd3, ACK = 3'd4;
  logic [2:0] state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic [6:0] ecnt_q, ecnt_d, ecnt_n;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d, tx_sh, rx_sh;
  logic [CS_NUM-1:0] cs_q, cs_d, sel_oh;
  logic ack_q, ack_d, sclk_q, sclk_d, mosi_q, mosi_d, hold_q, hold_d, oe_q, oe_d;
  logic tick, sample, rx_only;
`ifdef SPI_3WIRE_EN
  assign rx_only = spi_rx_only;
  assign spi_mosi_oe = oe_q;
`else
  assign rx_only = 1'b0;
`endif
  assign tick = cnt_q == HD_M1;
  assign ecnt_n = ecnt_q + 7'd1;
  // odd edges sample for CPHA=0, even edges for CPHA=1
  assign sample = ecnt_n[0] ^ SPI_CPHA;
  assign sel_oh = CS_NUM'(1) << spi_cs_sel;
  assign tx_sh = LSB_FIRST ? tx_q >> 1 : tx_q << 1;
  assign rx_sh = LSB_FIRST ? (rx_q >> 1) | (DATA_W'(spi_miso) << (DATA_W - 1))
                           : (rx_q << 1) | DATA_W'(spi_miso);
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q inside {SETUP, SHIFT, TAIL}) && !tick ? cnt_q + 28'd1 : 28'd0;
    ecnt_d = ecnt_q;
    tx_d = tx_q;
    rx_d = rx_q;
    dout_d = dout_q;
    ack_d = 1'b0;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cs_d = cs_q;
    hold_d = hold_q;
    oe_d = oe_q;
    case (state_q)
      IDLE: if (spi_wr_en) begin
        state_d = SETUP;
        ecnt_d = 7'd0;
        tx_d = spi_data_in;
        mosi_d = spi_data_in[FIRST];
        cs_d = CS_POL ? sel_oh : ~sel_oh;
        hold_d = spi_cs_hold;
        oe_d = ~rx_only;
      end
      SETUP: state_d = tick ? SHIFT : SETUP;
      SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        ecnt_d = ecnt_n;
        rx_d = sample ? rx_sh : rx_q;
        // advance only after a sample edge that is not the final one
        if (!sample && ecnt_n != 7'd1 && ecnt_n != LAST_EDGE) begin
          tx_d = tx_sh;
          mosi_d = tx_sh[FIRST];
        end
        state_d = ecnt_n == LAST_EDGE ? TAIL : SHIFT;
      end
      TAIL: if (tick) begin
        state_d = ACK;
        ack_d = 1'b1;
        dout_d = rx_q;
        oe_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cs_d = hold_q ? cs_q : CS_OFF;
      end
    endcase
  end
  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      state_q <= IDLE;
      cnt_q <= 28'd0;
      ecnt_q <= 7'd0;
      tx_q <= '0;
      rx_q <= '0;
      dout_q <= '0;
      ack_q <= 1'b0;
      sclk_q <= SPI_CPOL;
      mosi_q <= 1'b0;
      cs_q <= CS_OFF;
      hold_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ecnt_q <= ecnt_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      dout_q <= dout_d;
      ack_q <= ack_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_q <= cs_d;
      hold_q <= hold_d;
      oe_q <= oe_d;
    end
  end
  assign spi_data_out = dout_q;
  assign spi_wr_ack = ack_q;
  assign spi_busy = state_q != IDLE;
  assign spi_cs = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: three differently configured masters checked each cycle against a timing model
module tb_spi_master_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  int pw[3] = '{8, 8, 16};
  int ph[3] = '{25, 3, 1};
  int pcpol[3] = '{0, 0, 1};
  int pcpha[3] = '{0, 0, 1};
  int plsb[3] = '{0, 1, 0};
  int pcsn[3] = '{1, 1, 4};
  int pcspol[3] = '{1, 1, 0};
  logic wr[3] = '{default: 1'b0};
  logic hold[3] = '{default: 1'b0};
  logic rxo[3] = '{default: 1'b0};
  logic miso_m[3] = '{default: 1'b0};
  logic [31:0] din[3] = '{default: '0};
  logic [31:0] resp[3] = '{default: '0};
  logic [2:0] sel[3] = '{default: '0};
  logic ack[3], busy[3], sclk[3], mosi[3];
  logic [7:0] dout0, dout1;
  logic [15:0] dout2;
  logic cs0, cs1;
  logic [3:0] cs2;
`ifdef SPI_3WIRE_EN
  logic oe[3];
`endif
  bit m_act[3] = '{default: 1'b0};
  bit m_hold[3] = '{default: 1'b0};
  bit m_rxo[3] = '{default: 1'b0};
  int m_t[3] = '{default: 0};
  logic [31:0] m_data[3] = '{default: '0};
  logic [31:0] m_rx[3] = '{default: '0};
  logic [31:0] m_dout[3] = '{default: '0};
  logic [7:0] m_csidle[3] = '{default: '0};
  int m_sel[3] = '{default: 0};
  int ecnt[3] = '{default: 0};
  int nack[3] = '{default: 0};
  int ackj[3] = '{default: 0};
  logic [31:0] mword[3] = '{default: '0};
  logic psclk[3] = '{default: 1'b0};
  logic pmosi[3] = '{default: 1'b0};

  spi_master_gen u0 (
    .spi_clk(clk), .spi_rst_n(rst_n), .spi_wr_en(wr[0]), .spi_cs_sel(sel[0][0:0]),
    .spi_cs_hold(hold[0]), .spi_data_in(din[0][7:0]), .spi_data_out(dout0),
    .spi_wr_ack(ack[0]), .spi_busy(busy[0]), .spi_cs(cs0), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
`ifdef SPI_3WIRE_EN
    .spi_rx_only(rxo[0]), .spi_mosi_oe(oe[0]),
`endif
    .spi_miso(mosi[0]));
  spi_master_gen #(.SPI_SCLK(28'd8_333_333), .LSB_FIRST(1'b1)) u1 (
    .spi_clk(clk), .spi_rst_n(rst_n), .spi_wr_en(wr[1]), .spi_cs_sel(sel[1][0:0]),
    .spi_cs_hold(hold[1]), .spi_data_in(din[1][7:0]), .spi_data_out(dout1),
    .spi_wr_ack(ack[1]), .spi_busy(busy[1]), .spi_cs(cs1), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
`ifdef SPI_3WIRE_EN
    .spi_rx_only(rxo[1]), .spi_mosi_oe(oe[1]),
`endif
    .spi_miso(miso_m[1]));
  spi_master_gen #(.SYS_CLK(28'd10), .SPI_SCLK(28'd10), .DATA_W(16), .CS_NUM(4),
                   .SPI_CPOL(1'b1), .SPI_CPHA(1'b1), .CS_POL(1'b0)) u2 (
    .spi_clk(clk), .spi_rst_n(rst_n), .spi_wr_en(wr[2]), .spi_cs_sel(sel[2][1:0]),
    .spi_cs_hold(hold[2]), .spi_data_in(din[2][15:0]), .spi_data_out(dout2),
    .spi_wr_ack(ack[2]), .spi_busy(busy[2]), .spi_cs(cs2), .spi_sclk(sclk[2]), .spi_mosi(mosi[2]),
`ifdef SPI_3WIRE_EN
    .spi_rx_only(rxo[2]), .spi_mosi_oe(oe[2]),
`endif
    .spi_miso(miso_m[2]));

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask
  // total cycles from accept to the ack cycle
  function automatic int alen(int i);
    return (2 * pw[i] + 2) * ph[i];
  endfunction
  function automatic int nedg(int i, int j);
    int n = j / ph[i] - 1;
    return n < 0 ? 0 : (n > 2 * pw[i] ? 2 * pw[i] : n);
  endfunction
  function automatic logic [7:0] smask(int i, int s);
    return 8'((32'd1 << s) & ((32'd1 << pcsn[i]) - 32'd1));
  endfunction
  function automatic logic [31:0] wmask(int i);
    return (32'd1 << pw[i]) - 32'd1;
  endfunction

  bit idle_v;
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0;
        m_csidle[i] = '0;
        m_dout[i] = '0;
      end else begin
        idle_v = !m_act[i];
        if (m_act[i] && cyc - m_t[i] > alen(i)) begin
          m_act[i] = 1'b0;
          m_dout[i] = m_rx[i];
          m_csidle[i] = m_hold[i] ? smask(i, m_sel[i]) : 8'h00;
        end
        if (idle_v && wr[i]) begin
          m_act[i] = 1'b1;
          m_t[i] = cyc;
          m_data[i] = din[i] & wmask(i);
          m_rx[i] = (i == 0 ? din[i] : resp[i]) & wmask(i);
          m_sel[i] = int'(sel[i]);
          m_hold[i] = hold[i];
          m_rxo[i] = rxo[i];
        end
      end
    end
  end

  int cj, cn, cadv, cs_i;
  bit crun;
  logic [31:0] a_dout;
  logic [7:0] a_cs, csm;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cj = cyc - m_t[i];
      crun = m_act[i];
      cn = crun ? nedg(i, cj) : 0;
      a_dout = i == 0 ? 32'(dout0) : i == 1 ? 32'(dout1) : 32'(dout2);
      a_cs = i == 0 ? 8'(cs0) : i == 1 ? 8'(cs1) : 8'(cs2);
      csm = pcspol[i] == 1 ? a_cs : ~a_cs & smask(i, 0) * 8'h00 | (~a_cs & 8'((32'd1 << pcsn[i]) - 32'd1));
      chk("busy", i, 32'(busy[i]), 32'(crun));
      chk("ack", i, 32'(ack[i]), 32'(crun && cj == alen(i)));
      chk("sclk", i, 32'(sclk[i]), 32'(pcpol[i] ^ (cn & 1)));
      chk("cs", i, 32'(csm), 32'(crun ? smask(i, m_sel[i]) : m_csidle[i]));
      chk("data_out", i, a_dout, (crun && cj >= alen(i)) ? m_rx[i] : m_dout[i]);
      if (crun) begin
        cadv = cn < pcpha[i] ? 0 : (cn - pcpha[i]) / 2;
        if (cadv > pw[i] - 1) cadv = pw[i] - 1;
        cs_i = plsb[i] == 1 ? cadv : pw[i] - 1 - cadv;
        chk("mosi", i, 32'(mosi[i]), 32'(m_data[i][cs_i]));
      end
`ifdef SPI_3WIRE_EN
      chk("mosi_oe", i, 32'(oe[i]), 32'(crun && cj < alen(i) && !m_rxo[i]));
`endif
      if (crun && cj == 0) begin
        ecnt[i] = 0;
        mword[i] = '0;
      end else if (sclk[i] != psclk[i]) begin
        ecnt[i]++;
        if ((ecnt[i] % 2 == 1) != (pcpha[i] == 1)) mword[i] = {mword[i][30:0], pmosi[i]};
      end
      if (ack[i]) begin
        nack[i]++;
        ackj[i] = cj;
      end
      psclk[i] = sclk[i];
      pmosi[i] = mosi[i];
      if (i > 0 && crun) begin
        cs_i = pcpha[i] == 1 ? cn / 2 : (cn + 1) / 2;
        if (cs_i < pw[i]) miso_m[i] = m_rx[i][plsb[i] == 1 ? cs_i : pw[i] - 1 - cs_i];
      end
    end
  end

  task automatic send(int i, logic [31:0] d, logic [2:0] s, logic h, logic [31:0] r);
    din[i] = d;
    sel[i] = s;
    hold[i] = h;
    resp[i] = r;
    wr[i] = 1'b1;
    @(negedge clk);
    wr[i] = 1'b0;
  endtask
  task automatic wait_idle(int i);
    int k = 0;
    while (m_act[i] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (m_act[i]) begin
      tests++;
      fails++;
      $display("FAIL wait_idle dut%0d: still busy after %0d cycles, required idle", i, k);
    end
  endtask
  task automatic wait_j(int i, int jt);
    int k = 0;
    while (m_act[i] && cyc - m_t[i] != jt && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!m_act[i] || cyc - m_t[i] != jt) begin
      tests++;
      fails++;
      $display("FAIL wait_j dut%0d: offset %0d, required %0d", i, cyc - m_t[i], jt);
    end
  endtask

  int nbase;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sclk2", 2, 32'(sclk[2]), 32'h1);
    chk("rst_cs2", 2, 32'(cs2), 32'hF);
    chk("rst_dout0", 0, 32'(dout0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 32'hA5, 3'd0, 1'b0, 32'h0);
    wait_idle(0);
    chk("lit_mosi0", 0, 32'(mword[0][7:0]), 32'hA5);
    chk("lit_ackj0", 0, 32'(ackj[0]), 32'd450);
    chk("lit_dout0", 0, 32'(dout0), 32'hA5);
    send(1, 32'h81, 3'd0, 1'b0, 32'h3C);
    wait_idle(1);
    chk("lit_mosi1", 1, 32'(mword[1][7:0]), 32'h81);
    chk("lit_ackj1", 1, 32'(ackj[1]), 32'd54);
    chk("lit_dout1", 1, 32'(dout1), 32'h3C);
    send(2, 32'h1234, 3'd2, 1'b1, 32'hC3A5);
    wait_idle(2);
    chk("lit_edges2", 2, 32'(ecnt[2]), 32'd32);
    chk("lit_mosi2", 2, 32'(mword[2][15:0]), 32'h1234);
    chk("lit_hold_cs2", 2, 32'(cs2), 32'hB);
    repeat (4) @(negedge clk);
    send(2, 32'h5678, 3'd2, 1'b0, 32'h0FF0);
    wait_idle(2);
    chk("lit_dout2", 2, 32'(dout2), 32'h0FF0);
    chk("lit_rel_cs2", 2, 32'(cs2), 32'hF);
    send(2, 32'hAAAA, 3'd1, 1'b1, 32'h1234);
    wait_idle(2);
    send(2, 32'h5555, 3'd3, 1'b0, 32'h5A5A);
    wait_idle(2);
    nbase = nack[1];
    send(1, 32'h5A, 3'd0, 1'b0, 32'hE7);
    repeat (20) @(negedge clk);
    din[1] = 32'hFF;
    wr[1] = 1'b1;
    @(negedge clk);
    wr[1] = 1'b0;
    wait_j(1, 54);
    wr[1] = 1'b1;
    @(negedge clk);
    wr[1] = 1'b0;
    wait_idle(1);
    repeat (5) @(negedge clk);
    chk("lit_ack_count", 1, 32'(nack[1] - nbase), 32'd1);
    chk("lit_dout_ign", 1, 32'(dout1), 32'hE7);
    send(1, 32'h33, 3'd1, 1'b0, 32'h99);
    wait_idle(1);
    chk("lit_dout_nocs", 1, 32'(dout1), 32'h99);
    send(0, 32'h5A, 3'd0, 1'b0, 32'h0);
    wait_j(0, 149);
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_sclk0", 0, 32'(sclk[0]), 32'h0);
    chk("lit_rst_busy0", 0, 32'(busy[0]), 32'h0);
    chk("lit_rst_dout0", 0, 32'(dout0), 32'h0);
    chk("lit_rst_cs0", 0, 32'(cs0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 32'h3C, 3'd0, 1'b0, 32'h0);
    wait_idle(0);
    chk("lit_dout_after_rst", 0, 32'(dout0), 32'h3C);
`ifdef SPI_3WIRE_EN
    rxo[1] = 1'b1;
    send(1, 32'h00, 3'd0, 1'b0, 32'h6B);
    wait_idle(1);
    chk("lit_dout_rxonly", 1, 32'(dout1), 32'h6B);
    rxo[1] = 1'b0;
    send(1, 32'hC5, 3'd0, 1'b0, 32'h11);
    wait_j(1, 1);
    chk("lit_oe_on", 1, 32'(oe[1]), 32'h1);
    wait_idle(1);
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
